// File: rtl/ntt_bram_sched.sv
// ntt_bram_sched: stage/address scheduler for one in-place radix-2 DIF NTT
// coefficient bank. Walks LOG_N butterfly stages, issuing one BRAM read per
// cycle with a twiddle index and pair flag, and replays each read address on
// the write port LAT = 1 + BF_LAT cycles later. A LAT-cycle drain separates
// stages so the first read of a stage never overtakes the last write of the
// previous one.
// Optional macro NTT_SCHED_HOLD_EN adds a 'hold' input that freezes the
// sequence (and the write delay line) while asserted outside IDLE.
module ntt_bram_sched #(
    parameter int LOG_N  = 11,
    parameter int BF_LAT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
`ifdef NTT_SCHED_HOLD_EN
    input  logic                   hold,
`endif
    output logic                   busy,
    output logic                   done,
    output logic                   rd_en,
    output logic [LOG_N-1:0]       rd_addr,
    output logic                   bf_first,
    output logic [LOG_N-2:0]       tw_idx,
    output logic [$clog2(LOG_N):0] stage,
    output logic                   wr_en,
    output logic [LOG_N-1:0]       wr_addr
);
    localparam int N   = 1 << LOG_N;
    localparam int LAT = 1 + BF_LAT;
    localparam int SW  = $clog2(LOG_N) + 1;
    localparam int DW  = $clog2(LAT) + 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t                            state, state_nxt;
    logic   [LOG_N-1:0]                cnt, cnt_nxt;
    logic   [DW-1:0]                   dcnt, dcnt_nxt;
    logic   [SW-1:0]                   stg_nxt;
    logic                              rd_en_q;
    logic   [LAT-1:0]                  vld_pipe;
    logic   [LAT-1:0][LOG_N-1:0]       addr_pipe;
    logic                              freeze;

    logic                              busy_nxt, done_nxt, rd_en_nxt, bf_first_nxt;
    logic   [LOG_N-1:0]                rd_addr_nxt;
    logic   [LOG_N-2:0]                tw_idx_nxt;
    logic   [SW-1:0]                   sh;
    logic   [LOG_N-1:0]                k_w, half_w, lo_m, a_w, o_w, tw_w;

    // freeze only applies once a run is in flight
`ifdef NTT_SCHED_HOLD_EN
    assign freeze = hold && (state != IDLE);
`else
    assign freeze = 1'b0;
`endif

    // enables are gated by hold so a frozen cycle issues no BRAM access
    assign rd_en   = rd_en_q & ~freeze;
    assign wr_en   = vld_pipe[LAT-1] & ~freeze;
    assign wr_addr = addr_pipe[LAT-1];

    // state, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            dcnt     <= '0;
            stage    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_en_q  <= 1'b0;
            rd_addr  <= '0;
            bf_first <= 1'b0;
            tw_idx   <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            dcnt     <= dcnt_nxt;
            stage    <= stg_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            rd_en_q  <= rd_en_nxt;
            rd_addr  <= rd_addr_nxt;
            bf_first <= bf_first_nxt;
            tw_idx   <= tw_idx_nxt;
        end
    end

    // next state: N read cycles, LAT drain cycles, repeat per stage, then DONE
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        dcnt_nxt  = dcnt;
        stg_nxt   = stage;
        if (!freeze) begin
            case (state)
                IDLE: if (start) begin
                    state_nxt = READ;
                    cnt_nxt   = '0;
                    stg_nxt   = '0;
                end
                READ: if (cnt == LOG_N'(N - 1)) begin
                    state_nxt = DRAIN;
                    dcnt_nxt  = '0;
                end else begin
                    cnt_nxt = cnt + LOG_N'(1);
                end
                DRAIN: if (dcnt == DW'(LAT - 1)) begin
                    if (stage < SW'(LOG_N - 1)) begin
                        state_nxt = READ;
                        stg_nxt   = stage + SW'(1);
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = DONE;
                    end
                end else begin
                    dcnt_nxt = dcnt + DW'(1);
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // next outputs: pair addresses a/b and twiddle from shifts and masks
    always_comb begin
        sh           = SW'(LOG_N - 1) - stg_nxt;
        half_w       = LOG_N'(1) << sh;
        lo_m         = half_w - LOG_N'(1);
        k_w          = {1'b0, cnt_nxt[LOG_N-1:1]};
        o_w          = k_w & lo_m;
        a_w          = ((k_w & ~lo_m) << 1) | o_w;
        tw_w         = o_w << stg_nxt;
        rd_addr_nxt  = cnt_nxt[0] ? (a_w | half_w) : a_w;
        tw_idx_nxt   = tw_w[LOG_N-2:0];
        rd_en_nxt    = (state_nxt == READ);
        bf_first_nxt = (state_nxt == READ) && !cnt_nxt[0];
        busy_nxt     = (state_nxt != IDLE);
        done_nxt     = (state_nxt == DONE);
    end

    // write replay: read enable/address delayed LAT cycles, runs through drain
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe  <= '0;
            addr_pipe <= '0;
        end else if (!freeze) begin
            vld_pipe  <= {vld_pipe[LAT-2:0], rd_en_q};
            addr_pipe <= {addr_pipe[LAT-2:0], rd_addr};
        end
    end

endmodule

// File: tb/tb_ntt_bram_sched.sv
// Bench for ntt_bram_sched at LOG_N=3, BF_LAT=2 (LAT=3, run = 34 cycles).
// Expected traces come from hand-written address/twiddle tables per stage.
module tb_ntt_bram_sched;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       hold_drv = 1'b0;
    logic       busy, done, rd_en, bf_first, wr_en;
    logic [2:0] rd_addr, wr_addr, stage;
    logic [1:0] tw_idx;

    always #5 clk = ~clk;

    ntt_bram_sched #(.LOG_N(3), .BF_LAT(2)) dut (
        .clk(clk), .rst(rst), .start(start),
`ifdef NTT_SCHED_HOLD_EN
        .hold(hold_drv),
`endif
        .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
        .bf_first(bf_first), .tw_idx(tw_idx), .stage(stage),
        .wr_en(wr_en), .wr_addr(wr_addr)
    );

    typedef struct {
        bit rd_en; int rd_addr; bit bf_first; int tw;
        bit chk_stg; int stg;
        bit wr_en; int wr_addr;
        bit busy; bit done;
    } vec_t;

    int   ord [3][8] = '{'{0,4,1,5,2,6,3,7}, '{0,2,1,3,4,6,5,7}, '{0,1,2,3,4,5,6,7}};
    int   tws [3][8] = '{'{0,0,1,1,2,2,3,3}, '{0,0,2,2,0,0,2,2}, '{0,0,0,0,0,0,0,0}};
    vec_t base [40];
    vec_t exp_tab [64];
    bit   start_at [64];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic chk(input string nm, input int t, input logic [31:0] act, input logic [31:0] ex);
        n_total++;
        if (act !== ex) $display("FAIL %s cycle %0d: got %0d, expected %0d", nm, t, act, ex);
        else n_pass++;
    endtask

    function automatic vec_t idle_v();
        vec_t v;
        v = '{default: 0};
        return v;
    endfunction

    function automatic vec_t bv(input int t);
        if (t < 0 || t > 39) return idle_v();
        return base[t];
    endfunction

    task automatic check_vec(input int t, input vec_t e);
        chk("rd_en", t, {31'd0, rd_en}, {31'd0, e.rd_en});
        chk("wr_en", t, {31'd0, wr_en}, {31'd0, e.wr_en});
        chk("busy",  t, {31'd0, busy},  {31'd0, e.busy});
        chk("done",  t, {31'd0, done},  {31'd0, e.done});
        if (e.rd_en) begin
            chk("rd_addr",  t, {29'd0, rd_addr},  e.rd_addr);
            chk("bf_first", t, {31'd0, bf_first}, {31'd0, e.bf_first});
            chk("tw_idx",   t, {30'd0, tw_idx},   e.tw);
        end
        if (e.wr_en)   chk("wr_addr", t, {29'd0, wr_addr}, e.wr_addr);
        if (e.chk_stg) chk("stage",   t, {29'd0, stage},   e.stg);
    endtask

    // one cycle per iteration: drive at edge+1, sample at edge+3
    task automatic run(input int ncyc, input int rst_at, input int hold_lo, input int hold_hi);
        for (int t = 0; t < ncyc; t++) begin
            start    = start_at[t];
            rst      = (t == rst_at);
            hold_drv = (t >= hold_lo && t <= hold_hi);
            #2;
            check_vec(t, exp_tab[t]);
            @(posedge clk);
            #1;
        end
        start = 1'b0; rst = 1'b0; hold_drv = 1'b0;
        for (int t = 0; t < 64; t++) start_at[t] = 1'b0;
    endtask

    initial begin
        // expected trace of one full run starting from a start in cycle 0
        for (int t = 0; t < 40; t++) base[t] = idle_v();
        for (int t = 1; t <= 34; t++) base[t].busy = 1'b1;
        base[34].done = 1'b1;
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < 8; i++) begin
                int r;
                r = 1 + s * 11 + i;
                base[r].rd_en    = 1'b1;
                base[r].rd_addr  = ord[s][i];
                base[r].bf_first = (i % 2 == 0);
                base[r].tw       = tws[s][i];
                base[r].chk_stg  = 1'b1;
                base[r].stg      = s;
                base[r+3].wr_en   = 1'b1;
                base[r+3].wr_addr = ord[s][i];
            end
        end
        for (int t = 0; t < 64; t++) start_at[t] = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #2;
        chk("rst_busy",    -1, {31'd0, busy},     0);
        chk("rst_done",    -1, {31'd0, done},     0);
        chk("rst_rd_en",   -1, {31'd0, rd_en},    0);
        chk("rst_wr_en",   -1, {31'd0, wr_en},    0);
        chk("rst_bfirst",  -1, {31'd0, bf_first}, 0);
        chk("rst_rd_addr", -1, {29'd0, rd_addr},  0);
        chk("rst_wr_addr", -1, {29'd0, wr_addr},  0);
        chk("rst_tw_idx",  -1, {30'd0, tw_idx},   0);
        chk("rst_stage",   -1, {29'd0, stage},    0);
        @(posedge clk);
        #1;

        // run A: full transform, extra starts in cycles 5 and 34 are ignored
        for (int t = 0; t < 64; t++) exp_tab[t] = bv(t);
        start_at[0] = 1'b1; start_at[5] = 1'b1; start_at[34] = 1'b1;
        run(41, -1, -1, -1);

        // run B: reset in cycle 14, restart in cycle 16
        for (int t = 0; t < 64; t++) begin
            if (t <= 14)      exp_tab[t] = bv(t);
            else if (t == 15) begin exp_tab[t] = idle_v(); exp_tab[t].chk_stg = 1'b1; end
            else              exp_tab[t] = bv(t - 16);
        end
        start_at[0] = 1'b1; start_at[16] = 1'b1;
        run(56, 14, -1, -1);

`ifdef NTT_SCHED_HOLD_EN
        // run C: hold in cycles 6..8 stretches the run by 3 cycles
        for (int t = 0; t < 64; t++) begin
            if (t < 6)       exp_tab[t] = bv(t);
            else if (t <= 8) begin
                exp_tab[t] = bv(6);
                exp_tab[t].rd_en = 1'b0;
                exp_tab[t].wr_en = 1'b0;
            end
            else             exp_tab[t] = bv(t - 3);
        end
        start_at[0] = 1'b1;
        run(42, -1, 6, 8);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
